wishbone_master: RTL and testbench

WISHBONE_MASTER -- requirements
Module: wishbone_master

---
 rtl/wishbone_master.sv | 122 ++++++++++++
 tb/tb_wishbone_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone pipelined master: accepts one command at a time,
// drives a classic REQ/WAIT bus cycle and returns a one-cycle response strobe.
module wishbone_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [3:0]  cmd_we_i,
    input  logic [8:0]  cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [3:0]  wb_we_o,
    output logic [8:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  we_q, we_d;
    logic [8:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        ack_acc;
    logic        tmo_hit;

    // An ack only counts while the strobe has been taken (REQ without stall) or in WAIT.
    assign ack_acc = ((state_q == REQ) && !wb_stall_i && wb_ack_i) ||
                     ((state_q == WAIT) && wb_ack_i);
    assign tmo_hit = (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_data_i;
                    state_d = REQ;
                end
            end
            REQ, WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // Ack is checked before the timeout so a coincident ack wins.
                if (ack_acc) begin
                    rdata_d = (we_q == 4'b0000) ? wb_data_i : 32'd0;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if ((state_q == REQ) && !wb_stall_i) begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 4'd0;
            addr_q  <= 9'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_data_o  = rdata_q;
    assign rsp_err_o   = err_q;
    assign wb_cyc_o    = (state_q == REQ) || (state_q == WAIT);
    assign wb_stb_o    = (state_q == REQ);
    assign wb_we_o     = we_q;
    assign wb_addr_o   = addr_q;
    assign wb_data_o   = wdata_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Bench for wishbone_master: transaction-level model of expected bus/response
// behaviour, per-cycle compare on the falling edge, plus directed literal pins.
module tb_wishbone_master;
    localparam int T = 16;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [3:0]  cmd_we_i;
    logic [8:0]  cmd_addr_i;
    logic [31:0] cmd_data_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [3:0]  wb_we_o;
    logic [8:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic        wb_stall_i;

    always #5 clk_i = ~clk_i;

    wishbone_master #(.TIMEOUT(T)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
        .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
    );

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    logic        exp_ready, exp_rvalid, exp_rerr, exp_cyc, exp_stb;
    logic [3:0]  exp_we;
    logic [8:0]  exp_addr;
    logic [31:0] exp_wdata, exp_rdata;
    int          stb_seen, lat_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison of every output against the model's expectation.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("cmd_ready", 32'(cmd_ready_o), 32'(exp_ready));
            check("rsp_valid", 32'(rsp_valid_o), 32'(exp_rvalid));
            check("rsp_err", 32'(rsp_err_o), 32'(exp_rerr));
            check("rsp_data", rsp_data_o, exp_rdata);
            check("wb_cyc", 32'(wb_cyc_o), 32'(exp_cyc));
            check("wb_stb", 32'(wb_stb_o), 32'(exp_stb));
            check("wb_we", 32'(wb_we_o), 32'(exp_we));
            check("wb_addr", 32'(wb_addr_o), 32'(exp_addr));
            check("wb_data", wb_data_o, exp_wdata);
        end
    end

    task automatic set_reset_exp();
        exp_ready = 1'b1; exp_rvalid = 1'b0; exp_rerr = 1'b0; exp_cyc = 1'b0; exp_stb = 1'b0;
        exp_we = 4'd0; exp_addr = 9'd0; exp_wdata = 32'd0; exp_rdata = 32'd0;
    endtask

    task automatic idle_cycle(input bit ack1);
        exp_ready = 1'b1; exp_rvalid = 1'b0; exp_cyc = 1'b0; exp_stb = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_we_i = 4'($urandom); cmd_addr_i = 9'($urandom); cmd_data_i = $urandom;
        wb_ack_i = ack1 ? 1'b1 : 1'($urandom);
        wb_stall_i = 1'($urandom);
        wb_data_i = $urandom;
        @(posedge clk_i); #1;
    endtask

    // One transaction: s stalled REQ cycles, ack a cycles after the stall drops
    // (cycle s+a counted from REQ entry), or never when noack is set.
    task automatic run_txn(input logic [3:0] we, input logic [8:0] addr, input logic [31:0] wdat,
                           input int s, input int a, input bit noack,
                           input bit fix_rd, input logic [31:0] rd_val);
        int ack_k, end_k;
        bit err;
        logic [31:0] rd;
        exp_ready = 1'b1; exp_rvalid = 1'b0; exp_cyc = 1'b0; exp_stb = 1'b0;
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_data_i = wdat;
        wb_ack_i = 1'($urandom); wb_stall_i = 1'($urandom); wb_data_i = $urandom;
        @(posedge clk_i); #1;
        exp_we = we; exp_addr = addr; exp_wdata = wdat;
        ack_k = noack ? 32'h4000_0000 : s + a;
        if (ack_k <= T - 1) begin end_k = ack_k + 1; err = 1'b0; end
        else begin end_k = T; err = 1'b1; end
        stb_seen = 0; lat_seen = -1; rd = 32'd0;
        for (int k = 0; k < end_k; k++) begin
            exp_ready = 1'b0; exp_rvalid = 1'b0; exp_cyc = 1'b1; exp_stb = (k <= s);
            cmd_valid_i = 1'($urandom);
            cmd_we_i = 4'($urandom); cmd_addr_i = 9'($urandom); cmd_data_i = $urandom;
            wb_data_i = (fix_rd && k == ack_k) ? rd_val : $urandom;
            wb_stall_i = (k < s) ? 1'b1 : ((k == s) ? 1'b0 : 1'($urandom));
            wb_ack_i = (k == ack_k);
            if (k == ack_k) rd = wb_data_i;
            if (wb_stb_o) stb_seen++;
            if (rsp_valid_o && lat_seen < 0) lat_seen = k;
            @(posedge clk_i); #1;
        end
        exp_ready = 1'b0; exp_rvalid = 1'b1; exp_cyc = 1'b0; exp_stb = 1'b0;
        exp_rerr = err;
        exp_rdata = (err || we != 4'b0000) ? 32'd0 : rd;
        cmd_valid_i = 1'($urandom);
        wb_ack_i = 1'($urandom); wb_stall_i = 1'($urandom); wb_data_i = $urandom;
        if (rsp_valid_o && lat_seen < 0) lat_seen = end_k;
        @(posedge clk_i); #1;
        exp_ready = 1'b1; exp_rvalid = 1'b0;
        cmd_valid_i = 1'b0;
    endtask

    initial begin
        logic [3:0] rwe;
        int rs, ra;
        bit rno;
        rst_n_i = 1'b0;
        cmd_valid_i = 1'b0; cmd_we_i = 4'd0; cmd_addr_i = 9'd0; cmd_data_i = 32'd0;
        wb_data_i = 32'd0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;
        set_reset_exp();
        chk_en = 1'b1;
        #1;
        check("reset_ready", 32'(cmd_ready_o), 32'd1);
        check("reset_cyc", 32'(wb_cyc_o), 32'd0);
        check("reset_rvalid", 32'(rsp_valid_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        // Write, ack one cycle after the strobe.
        run_txn(4'hF, 9'h000, 32'h0000FFFF, 0, 1, 1'b0, 1'b0, 32'd0);
        check("wr_stb_cycles", 32'(stb_seen), 32'd1);
        check("wr_latency", 32'(lat_seen), 32'd2);
        check("wr_err", 32'(rsp_err_o), 32'd0);
        check("wr_data", rsp_data_o, 32'd0);

        // Read with five stall cycles.
        run_txn(4'h0, 9'h101, 32'h12345678, 5, 2, 1'b0, 1'b1, 32'h0000DDDD);
        check("stall_stb_cycles", 32'(stb_seen), 32'd6);
        check("stall_latency", 32'(lat_seen), 32'd8);
        check("stall_rdata", rsp_data_o, 32'h0000DDDD);
        idle_cycle(1'b0);

        // Timeout with no ack at all.
        run_txn(4'h0, 9'h055, 32'd0, 0, 0, 1'b1, 1'b0, 32'd0);
        check("tmo_latency", 32'(lat_seen), 32'd16);
        check("tmo_err", 32'(rsp_err_o), 32'd1);
        check("tmo_data", rsp_data_o, 32'd0);

        // Ack in WAIT on the timeout cycle.
        run_txn(4'h0, 9'h1F0, 32'd0, 3, 12, 1'b0, 1'b1, 32'hC0DE1234);
        check("coin_wait_latency", 32'(lat_seen), 32'd16);
        check("coin_wait_err", 32'(rsp_err_o), 32'd0);
        check("coin_wait_data", rsp_data_o, 32'hC0DE1234);

        // Ack in the first unstalled REQ cycle, which is also the timeout cycle.
        run_txn(4'h0, 9'h0F0, 32'd0, 15, 0, 1'b0, 1'b1, 32'h5A5A0001);
        check("coin_req_stb_cycles", 32'(stb_seen), 32'd16);
        check("coin_req_err", 32'(rsp_err_o), 32'd0);
        check("coin_req_data", rsp_data_o, 32'h5A5A0001);

        // Same-cycle ack skips WAIT.
        run_txn(4'h0, 9'h033, 32'd0, 0, 0, 1'b0, 1'b1, 32'hBEEF0042);
        check("skipwait_latency", 32'(lat_seen), 32'd1);
        check("skipwait_stb_cycles", 32'(stb_seen), 32'd1);

        // Spurious acks in IDLE.
        repeat (3) begin
            idle_cycle(1'b1);
            check("spur_ready", 32'(cmd_ready_o), 32'd1);
            check("spur_rvalid", 32'(rsp_valid_o), 32'd0);
        end

        // Reset during WAIT.
        cmd_valid_i = 1'b1; cmd_we_i = 4'h0; cmd_addr_i = 9'h0AA; cmd_data_i = 32'h0BADF00D;
        wb_ack_i = 1'b0; wb_stall_i = 1'b0;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        exp_we = 4'h0; exp_addr = 9'h0AA; exp_wdata = 32'h0BADF00D;
        exp_ready = 1'b0; exp_rvalid = 1'b0; exp_cyc = 1'b1; exp_stb = 1'b1;
        @(posedge clk_i); #1;
        exp_stb = 1'b0;
        @(posedge clk_i); #1;
        #2;
        rst_n_i = 1'b0;
        set_reset_exp();
        #1;
        check("rst_cyc_async", 32'(wb_cyc_o), 32'd0);
        check("rst_stb_async", 32'(wb_stb_o), 32'd0);
        check("rst_ready_async", 32'(cmd_ready_o), 32'd1);
        wb_ack_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        wb_ack_i = 1'b0;
        rst_n_i = 1'b1;
        run_txn(4'h0, 9'h1AB, 32'd0, 1, 1, 1'b0, 1'b1, 32'h600DCAFE);
        check("post_rst_latency", 32'(lat_seen), 32'd3);
        check("post_rst_data", rsp_data_o, 32'h600DCAFE);

        // Randomized traffic.
        for (int i = 0; i < 120; i++) begin
            rwe = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            rs = ($urandom_range(0, 9) < 6) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 20));
            ra = ($urandom_range(0, 9) < 6) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 18));
            rno = ($urandom_range(0, 9) == 0);
            run_txn(rwe, 9'($urandom), $urandom, rs, ra, rno, 1'b0, 32'd0);
            repeat ($urandom_range(0, 2)) idle_cycle(1'b0);
        end

        idle_cycle(1'b0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
